// File: rtl/alu_pkg.sv
// Shared encodings for the ALU / multiply-divide slice: ALU operation codes,
// multiply/divide operation codes, engine FSM states and shift-amount width.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SRL  = 4'b0011,
      ALU_SLL  = 4'b0100,
      ALU_SRA  = 4'b0101,
      ALU_SUB  = 4'b0110,
      ALU_SLT  = 4'b0111,
      ALU_SLTU = 4'b1000
   } alu_op_e;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_e;

   // Number of low-order bits of rs used as a shift amount.
   function automatic int unsigned shamt_w(input int unsigned width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative multiply/divide engine: IDLE -> RUN -> FIX -> IDLE.
// RUN does one shift-add (multiply) or restoring-subtract (divide) step per
// cycle on operand magnitudes; FIX spends one cycle on sign correction and one
// cycle committing hi/lo. Divide hardware exists only with ALU_MULDIV_DIV_EN.
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int unsigned SW = shamt_w(WIDTH);

   state_e           state_q, state_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             is_div_q, is_div_d;
   logic             neg_lo_q, neg_lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             op_signed;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   mul_sum;
   logic [2*WIDTH-1:0] prod_neg;

`ifdef ALU_MULDIV_DIV_EN
   logic             neg_hi_q, neg_hi_d;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_diff;
`endif

   // Operand magnitudes and per-step arithmetic shared by the FSM.
   always_comb begin
      op_signed = ~op_i[0];
      a_neg     = op_signed & a_i[WIDTH-1];
      b_neg     = op_signed & b_i[WIDTH-1];
      a_mag     = a_neg ? ('0 - a_i) : a_i;
      b_mag     = b_neg ? ('0 - b_i) : b_i;
      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
      prod_neg  = '0 - {acc_hi_q, acc_lo_q};
`ifdef ALU_MULDIV_DIV_EN
      rem_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
      // Bit WIDTH of the difference is the borrow: set when rem_sh < divisor.
      rem_diff  = rem_sh - {1'b0, opb_q};
`endif
   end

   // Next-state, datapath and output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opb_d    = opb_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
`ifdef ALU_MULDIV_DIV_EN
      neg_hi_d = neg_hi_q;
`endif
      done_d   = 1'b0;
      // busy lags the state by one edge and drops on the commit edge.
      busy_d   = (state_q != S_IDLE) && !((state_q == S_FIX) && (cnt_q == SW'(1)));

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               is_div_d = op_i[1];
               cnt_d    = '0;
               if (!op_i[1]) begin
                  acc_hi_d = '0;
                  acc_lo_d = a_mag;
                  opb_d    = b_mag;
                  neg_lo_d = a_neg ^ b_neg;
                  state_d  = S_RUN;
               end else begin
`ifdef ALU_MULDIV_DIV_EN
                  if (b_i == '0) begin
                     // Divide by zero: result preloaded, correction is identity.
                     acc_hi_d = a_i;
                     acc_lo_d = '1;
                     neg_lo_d = 1'b0;
                     neg_hi_d = 1'b0;
                     state_d  = S_FIX;
                  end else begin
                     acc_hi_d = '0;
                     acc_lo_d = a_mag;
                     opb_d    = b_mag;
                     neg_lo_d = a_neg ^ b_neg;
                     neg_hi_d = a_neg;
                     state_d  = S_RUN;
                  end
`else
                  // No divider: jump straight to the commit cycle, which skips the write.
                  state_d = S_FIX;
                  cnt_d   = SW'(1);
`endif
               end
            end
         end

         S_RUN: begin
`ifdef ALU_MULDIV_DIV_EN
            if (is_div_q) begin
               acc_hi_d = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
               acc_lo_d = {acc_lo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
            end else begin
               {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
            end
`else
            {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
`endif
            if (cnt_q == SW'(WIDTH-1)) begin
               cnt_d   = '0;
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q + SW'(1);
            end
         end

         S_FIX: begin
            if (cnt_q == '0) begin
               cnt_d = SW'(1);
`ifdef ALU_MULDIV_DIV_EN
               if (is_div_q) begin
                  acc_lo_d = neg_lo_q ? ('0 - acc_lo_q) : acc_lo_q;
                  acc_hi_d = neg_hi_q ? ('0 - acc_hi_q) : acc_hi_q;
               end else if (neg_lo_q) begin
                  {acc_hi_d, acc_lo_d} = prod_neg;
               end
`else
               if (neg_lo_q) begin
                  {acc_hi_d, acc_lo_d} = prod_neg;
               end
`endif
            end else begin
`ifdef ALU_MULDIV_DIV_EN
               hi_d = acc_hi_q;
               lo_d = acc_lo_q;
`else
               if (!is_div_q) begin
                  hi_d = acc_hi_q;
                  lo_d = acc_lo_q;
               end
`endif
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Engine state and architected hi/lo registers, asynchronously reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opb_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
         neg_hi_q <= 1'b0;
`endif
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opb_q    <= opb_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
`ifdef ALU_MULDIV_DIV_EN
         neg_hi_q <= neg_hi_d;
`endif
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: rtl/alu_muldiv.sv
// ALU with iterative multiply/divide unit. The combinational ALU lives here;
// the multi-cycle engine is alu_muldiv_seq. Divide support is compiled in
// only when ALU_MULDIV_DIV_EN is defined.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_s,
   input  logic [WIDTH-1:0] data_t,
   input  logic [3:0]       alu_control,
   input  logic             md_start,
   input  logic [1:0]       md_op,
   output logic [WIDTH-1:0] out_alu,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int unsigned SW = shamt_w(WIDTH);

   logic [SW-1:0] shamt;

   assign shamt = data_s[SW-1:0];

   // Combinational ALU; independent of reset and of the engine state.
   always_comb begin
      out_alu = '0;
      case (alu_control)
         ALU_AND:  out_alu = data_s & data_t;
         ALU_OR:   out_alu = data_s | data_t;
         ALU_ADD:  out_alu = data_s + data_t;
         ALU_SUB:  out_alu = data_s - data_t;
         ALU_SLT:  out_alu = {{(WIDTH-1){1'b0}}, ($signed(data_s) < $signed(data_t))};
         ALU_SLTU: out_alu = {{(WIDTH-1){1'b0}}, (data_s < data_t)};
         ALU_SLL:  out_alu = data_t << shamt;
         ALU_SRL:  out_alu = data_t >> shamt;
         ALU_SRA:  out_alu = $signed(data_t) >>> shamt;
         default:  out_alu = '0;
      endcase
   end

   assign zero = (out_alu == '0);

   alu_muldiv_seq #(
      .WIDTH(WIDTH)
   ) u_seq (
      .clk_i   (clk),
      .rst_i   (reset),
      .a_i     (data_s),
      .b_i     (data_t),
      .start_i (md_start),
      .op_i    (md_op),
      .hi_o    (hi),
      .lo_o    (lo),
      .busy_o  (busy),
      .done_o  (done)
   );

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): table-driven ALU vectors,
// random ALU and multiply/divide traffic against an arithmetic reference,
// plus directed multi-cycle sequences (ignored start, back-to-back, reset).
module tb_alu_muldiv;

   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  data_s, data_t;
   logic [3:0]    alu_control;
   logic          md_start;
   logic [1:0]    md_op;
   logic [W-1:0]  out_alu, hi, lo;
   logic          zero, busy, done;

   int nerr = 0;
   int nchk = 0;

   // Architected hi/lo as the reference expects them.
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   typedef struct {
      logic [3:0]   c;
      logic [W-1:0] s;
      logic [W-1:0] t;
      logic [W-1:0] e;
   } vec_t;

   vec_t vecs[12];

   alu_muldiv #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .data_s      (data_s),
      .data_t      (data_t),
      .alu_control (alu_control),
      .md_start    (md_start),
      .md_op       (md_op),
      .out_alu     (out_alu),
      .zero        (zero),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] alu_ref(input logic [3:0] c, input logic [W-1:0] s, input logic [W-1:0] t);
      int unsigned sh;
      sh = s % W;
      case (c)
         4'b0000: return s & t;
         4'b0001: return s | t;
         4'b0010: return s + t;
         4'b0110: return s - t;
         4'b0111: return (int'(s) < int'(t)) ? 32'd1 : 32'd0;
         4'b1000: return (s < t) ? 32'd1 : 32'd0;
         4'b0100: return t << sh;
         4'b0011: return t >> sh;
         4'b0101: return (t >> sh) | (t[W-1] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
         default: return 32'd0;
      endcase
   endfunction

   // Expected hi/lo and latency (edges after acceptance until done is seen).
   task automatic md_ref(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eh, output logic [W-1:0] el, output int lat);
      logic [63:0] p;
      eh  = m_hi;
      el  = m_lo;
      lat = W + 2;
      case (op)
         2'b00: begin
            p = longint'(int'(a)) * longint'(int'(b));
            {eh, el} = p;
         end
         2'b01: begin
            p = {32'd0, a} * {32'd0, b};
            {eh, el} = p;
         end
         default: begin
`ifdef ALU_MULDIV_DIV_EN
            if (b == 0) begin
               eh  = a;
               el  = '1;
               lat = 2;
            end else if (op == 2'b10) begin
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                  el = 32'h8000_0000;
                  eh = 32'd0;
               end else begin
                  el = int'(a) / int'(b);
                  eh = int'(a) % int'(b);
               end
            end else begin
               el = a / b;
               eh = a % b;
            end
`else
            lat = 1;
`endif
         end
      endcase
   endtask

   // Issue one operation (unless already driven by a chained done cycle),
   // optionally re-request at edge k+ignore_at, and check latency, busy
   // profile, results and single-cycle done.
   task automatic md_check(input string name, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit pre_driven, input int ignore_at,
                           input bit chain, input logic [1:0] nop, input logic [W-1:0] na,
                           input logic [W-1:0] nb);
      logic [W-1:0] eh, el;
      int lat, n, bad;
      bit seen;
      md_ref(op, a, b, eh, el, lat);
      if (!pre_driven) begin
         @(posedge clk); #1;
         md_start = 1'b1; md_op = op; data_s = a; data_t = b;
      end
      @(posedge clk); #1;
      md_start = 1'b0; data_s = $urandom; data_t = $urandom;
      bad = (busy !== 1'b0 || done !== 1'b0) ? 1 : 0;
      n = 0;
      seen = 0;
      while (!seen && n < lat + 10) begin
         @(posedge clk); n++; #1;
         md_start = 1'b0;
         if (n == ignore_at - 1) begin
            md_start = 1'b1; md_op = op ^ 2'b01; data_s = $urandom; data_t = $urandom;
         end
         if (done === 1'b1) seen = 1;
         if (busy !== ((n < lat) ? 1'b1 : 1'b0)) bad++;
         if (n == 3 && !seen) begin
            alu_control = 4'b0010; data_s = 32'h0000_0007; data_t = 32'h0000_0009;
            #1 chk({name, " alu while busy"}, out_alu, 32'h10);
         end
      end
      chk({name, " latency"}, seen ? n : -1, lat);
      chk({name, " busy profile errors"}, bad, 0);
      chk({name, " hi"}, hi, eh);
      chk({name, " lo"}, lo, el);
      m_hi = eh;
      m_lo = el;
      if (chain) begin
         md_start = 1'b1; md_op = nop; data_s = na; data_t = nb;
      end else begin
         @(posedge clk); #1;
         chk({name, " done one cycle"}, done, 1'b0);
         chk({name, " busy after done"}, busy, 1'b0);
      end
   endtask

   initial begin
      logic [1:0]   op;
      logic [W-1:0] a, b, e;
      logic [3:0]   c;
      int           npulse;

      reset = 1'b1; md_start = 1'b0; md_op = 2'b00;
      data_s = '0; data_t = '0; alu_control = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset hi", hi, 32'd0);
      chk("reset lo", lo, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      vecs[0]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000}; // ADD wrap
      vecs[1]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001}; // SLT -1<1
      vecs[2]  = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000}; // SLTU
      vecs[3]  = '{4'b0101, 32'h0000_0024, 32'h8000_0000, 32'hF800_0000}; // SRA by 4
      vecs[4]  = '{4'b0011, 32'h0000_0024, 32'h8000_0000, 32'h0800_0000}; // SRL by 4
      vecs[5]  = '{4'b0100, 32'h0000_0021, 32'h0000_0003, 32'h0000_0006}; // SLL by 1
      vecs[6]  = '{4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF}; // SUB wrap
      vecs[7]  = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000}; // AND
      vecs[8]  = '{4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0}; // OR
      vecs[9]  = '{4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000}; // unused code
      vecs[10] = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000}; // SUB equal
      vecs[11] = '{4'b0111, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000}; // SLT vs min

      for (int i = 0; i < 12; i++) begin
         alu_control = vecs[i].c; data_s = vecs[i].s; data_t = vecs[i].t;
         #1;
         chk($sformatf("vec%0d out_alu", i), out_alu, vecs[i].e);
         chk($sformatf("vec%0d zero", i), zero, (vecs[i].e == 0) ? 1'b1 : 1'b0);
      end

      for (int i = 0; i < 100; i++) begin
         c = 4'($urandom_range(0, 15));
         a = $urandom; b = $urandom;
         if ($urandom_range(0, 5) == 0) b = a;
         alu_control = c; data_s = a; data_t = b;
         #1;
         e = alu_ref(c, a, b);
         chk($sformatf("rand alu op%0h out_alu", c), out_alu, e);
         chk($sformatf("rand alu op%0h zero", c), zero, (e == 0) ? 1'b1 : 1'b0);
      end

      // MULT -3 x 7 with a second request at k+5 that must be ignored.
      md_check("mult -3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 0, 5, 0, 2'b00, '0, '0);
      chk("mult -3x7 hi const", hi, 32'hFFFF_FFFF);
      chk("mult -3x7 lo const", lo, 32'hFFFF_FFEB);

      md_check("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 2'b00, '0, '0);
`ifdef ALU_MULDIV_DIV_EN
      chk("div -7/2 lo const", lo, 32'hFFFF_FFFD);
      chk("div -7/2 hi const", hi, 32'hFFFF_FFFF);
`else
      chk("div disabled hi kept", hi, 32'hFFFF_FFFF);
      chk("div disabled lo kept", lo, 32'hFFFF_FFEB);
`endif
      md_check("divu 7/0", 2'b11, 32'd7, 32'd0, 0, 0, 0, 2'b00, '0, '0);
`ifdef ALU_MULDIV_DIV_EN
      chk("divu 7/0 hi const", hi, 32'd7);
      chk("divu 7/0 lo const", lo, 32'hFFFF_FFFF);
`endif
      md_check("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 2'b00, '0, '0);

      // Back-to-back: MULTU issued on the done cycle of the previous op.
      md_check("mult 3x5", 2'b00, 32'd3, 32'd5, 0, 0, 1, 2'b01, 32'hFFFF_FFFF, 32'd2);
      md_check("multu b2b", 2'b01, 32'hFFFF_FFFF, 32'd2, 1, 0, 0, 2'b00, '0, '0);
      chk("multu b2b hi const", hi, 32'd1);
      chk("multu b2b lo const", lo, 32'hFFFF_FFFE);

      for (int i = 0; i < 16; i++) begin
         op = 2'($urandom_range(0, 3));
         a = $urandom; b = $urandom;
         if ($urandom_range(0, 7) == 0) b = 32'd0;
         if ($urandom_range(0, 7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
         md_check($sformatf("rand md op%0d", op), op, a, b, 0, 0, 0, 2'b00, '0, '0);
      end

      // Reset asserted before edge k+10 of a MULT: immediate clear, no done later.
      md_check("multu pre-reset", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, 2'b00, '0, '0);
      @(posedge clk); #1;
      md_start = 1'b1; md_op = 2'b00; data_s = 32'h0000_1234; data_t = 32'hFFFF_0003;
      @(posedge clk); #1;
      md_start = 1'b0;
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("mid reset busy", busy, 1'b0);
      chk("mid reset hi", hi, 32'd0);
      chk("mid reset lo", lo, 32'd0);
      chk("mid reset done", done, 1'b0);
      m_hi = '0;
      m_lo = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      npulse = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (done !== 1'b0 || busy !== 1'b0) npulse++;
      end
      chk("post reset done/busy activity", npulse, 0);
      md_check("mult after reset", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 2'b00, '0, '0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
